// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier, signed/unsigned, full 2N-bit product.
// Optional macro SEQ_MULT_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] opA,
  input  logic [N-1:0] opB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out_lo,
  output logic [N-1:0] out_hi
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic           mode_q, mode_d;
  logic           neg_q, neg_d;
  logic [N-1:0]   mag_q, mag_d;
  logic [N-1:0]   mplr_q, mplr_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] out_q, out_d;

  logic           a_neg, b_neg, last_iter;
  logic [2*N-1:0] addend, acc_sum;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    a_neg   = signed_mode & opA[N-1];
    b_neg   = signed_mode & opB[N-1];
    addend  = mplr_q[0] ? ({{N{1'b0}}, mag_q} << cnt_q) : '0;
    acc_sum = acc_q + addend;
`ifdef SEQ_MULT_EARLY_TERM_EN
    last_iter = (cnt_q == LAST_CNT) || (mplr_q[N-1:1] == '0);
`else
    last_iter = (cnt_q == LAST_CNT);
`endif

    case (state_q)
      RUN: begin
        acc_d  = acc_sum;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = DONE;
          out_d   = (mode_q && neg_q) ? (~acc_sum + ONE_2N) : acc_sum;
        end
      end
      default: begin
        if (start) begin
          // Magnitude of -2^(N-1) wraps to 2^(N-1), which is the correct unsigned value
          state_d = RUN;
          mode_d  = signed_mode;
          neg_d   = a_neg ^ b_neg;
          mag_d   = a_neg ? (~opA + ONE_N) : opA;
          mplr_d  = b_neg ? (~opB + ONE_N) : opB;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign out_lo = out_q[N-1:0];
  assign out_hi = out_q[2*N-1:N];

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=16): vector table, random vectors and
// hand-written handshake/reset sequences, with a scoreboard queue of expected products.
module tb_seq_multiplier;

  logic        clk, rst, start, signed_mode;
  logic [15:0] opA, opB, out_lo, out_hi;
  logic        busy, done;

  int          nApplied = 0;
  int          nMiss    = 0;
  logic [31:0] sbQueue[$];
  logic [31:0] lastResult = '0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs[11];

  seq_multiplier #(.N(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(signed_mode),
    .opA        (opA),
    .opB        (opB),
    .busy       (busy),
    .done       (done),
    .out_lo     (out_lo),
    .out_hi     (out_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference product using the native multiply operator on sign- or zero-extended operands
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    logic signed [31:0] sa, sb;
    if (sgn) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return sa * sb;
    end
    return {16'h0, a} * {16'h0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; start is held across exactly one rising edge
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                               input logic [31:0] exp);
    start       = 1'b1;
    opA         = a;
    opB         = b;
    signed_mode = sgn;
    sbQueue.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    opA   = $urandom;
    opB   = $urandom;
  endtask

  task automatic waitResult(output int busyCyc, output bit ok);
    int cyc = 0;
    busyCyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busyCyc++;
      @(negedge clk);
      cyc++;
    end
    ok = (done === 1'b1);
    if (!ok) begin
      nApplied++;
      nMiss++;
      $display("[TB] FAIL timeout: done still low after %0d cycles, expected 1", cyc);
      if (sbQueue.size() > 0) void'(sbQueue.pop_front());
    end
  endtask

  task automatic checkOutput(input string name);
    logic [31:0] exp;
    if (sbQueue.size() == 0) begin
      nApplied++;
      nMiss++;
      $display("[TB] FAIL %s: done with empty scoreboard, got 0x%08h", name, {out_hi, out_lo});
    end else begin
      exp = sbQueue.pop_front();
      check(name, {out_hi, out_lo}, exp);
      lastResult = exp;
    end
  endtask

  initial begin
    int  bc;
    bit  ok;
    int  doneSeen;
    logic [15:0] ra, rb;
    logic        rs;

    vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vecs[1]  = '{16'hFFFF, 16'h0003, 1'b1, 32'hFFFF_FFFD};
    vecs[2]  = '{16'hFFFF, 16'h0003, 1'b0, 32'h0002_FFFD};
    vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000};
    vecs[5]  = '{16'h0000, 16'h1234, 1'b0, 32'h0000_0000};
    vecs[6]  = '{16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000};
    vecs[7]  = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060};
    vecs[8]  = '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
    vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 32'h0000_0000};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; opA = '0; opB = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_out", {out_hi, out_lo}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].prod);
      waitResult(bc, ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d", i));
        check($sformatf("vec%0d_busy_cycles", i), bc, 32'd16);
      end
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'h0, done}, 32'h0);
      check($sformatf("vec%0d_hold", i), {out_hi, out_lo}, lastResult);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rs, model(ra, rb, rs));
      waitResult(bc, ok);
      if (ok) checkOutput($sformatf("rand%0d", i));
      @(negedge clk);
    end

    // start while busy is dropped; start during DONE is accepted back-to-back
    applyStimulus(16'h0003, 16'h0005, 1'b0, 32'h0000_000F);
    repeat (4) @(negedge clk);
    check("run_hold", {out_hi, out_lo}, lastResult);
    start = 1'b1; opA = 16'h0007; opB = 16'h0007;
    @(negedge clk);
    start = 1'b0;
    waitResult(bc, ok);
    if (ok) begin
      checkOutput("ignored_start");
      applyStimulus(16'h0007, 16'h0007, 1'b0, 32'h0000_0031);
      check("b2b_busy", {31'h0, busy}, 32'h1);
      waitResult(bc, ok);
      if (ok) begin
        checkOutput("back_to_back");
        check("b2b_busy_cycles", bc, 32'd16);
      end
    end
    @(negedge clk);

    // Reset mid-operation aborts without a done pulse
    applyStimulus(16'h1234, 16'h5678, 1'b0, 32'h0626_0060);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_out", {out_hi, out_lo}, 32'h0);
    sbQueue.delete();
    lastResult = '0;
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    check("abort_no_done", doneSeen, 32'd0);
    applyStimulus(16'h1234, 16'h5678, 1'b0, 32'h0626_0060);
    waitResult(bc, ok);
    if (ok) checkOutput("after_abort");
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative radix-2 shift-add multiplier. Next-generation replacement for the ALU's combinational N-bit multiply.
- Generalisations over the current multiply:
  - Parametrised width.
  - Full 2N-bit product, split into high and low words.
  - Signed/unsigned mode selected per operation.
  - Start/done handshake so a multiply can span several cycles without a long combinational path.
- Instantiated beside the ALU. The control unit stalls on busy.

Parameters:
- N, 16, operand width in bits (N >= 2). Product width is 2N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply. Accepted only when busy=0.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- opA  input  N  multiplicand. Sampled with start.
- opB  input  N  multiplier. Sampled with start.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse: result valid.
- out_lo  output  N  product bits [N-1:0].
- out_hi  output  N  product bits [2N-1:N].

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE
  - busy=0, done=0
  - out_lo=0, out_hi=0
  - all internal registers cleared.
- Reset asserted mid-operation aborts the multiply. No done pulse is produced for it.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE/DONE -> RUN on start=1.
  - DONE -> IDLE on start=0.
  - RUN -> DONE when the final iteration completes.
- Accept edge (start=1 and busy=0):
  - Latch signed_mode.
  - |opA| goes into an N-bit magnitude register. |opB| goes into a shift register.
  - When signed_mode=1, latch neg = opA[N-1] XOR opB[N-1]; otherwise neg = 0.
  - Clear the 2N-bit accumulator and the iteration counter.
- Magnitude rule:
  - Magnitude is the N-bit two's-complement negation when the sign bit is set, otherwise the value unchanged.
  - The magnitude of -2^(N-1) is 2^(N-1) as an unsigned N-bit value. This case is correct with no special handling.
- Each RUN cycle (iteration i = 0..N-1):
  - If the multiplier LSB is 1, add the magnitude shifted left by i into the accumulator.
  - Shift the multiplier right by 1. Increment the counter.
- Completion: the edge that finishes iteration N-1 does both of the following:
  - Register out = neg ? -acc : acc, modulo 2^2N, into out_hi:out_lo.
  - Enter DONE.
- Latency: start accepted at edge 0 -> done=1 during the cycle after edge N. RUN lasts exactly N cycles.
- Output hold:
  - out_hi and out_lo hold their value from the DONE entry until the next completion or reset.
  - They do not change during RUN.
- Handshake:
  - start while busy=1 is ignored. No queuing; the operands are dropped.
  - start during DONE is accepted (back-to-back). Throughput is one result per N+1 cycles.
- Unsigned mode: the result is the exact 2N-bit unsigned product. It never overflows.
- Signed mode: the result is the exact 2N-bit two's-complement product. out_lo alone equals the current N-bit truncated multiply.
- opA or opB equal to 0: the result is 0 in both modes. neg has no effect because -0 = 0.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- When defined: RUN also exits to DONE after any iteration whose post-shift multiplier is 0.
  - RUN cycles = max(1, position of the highest set bit of |opB| + 1).
  - The result is identical to the full-length run.
  - busy drops correspondingly earlier.
- When undefined: RUN is always exactly N cycles, giving constant latency.

Test Plan (N=16):
- Unsigned, opA=0xFFFF, opB=0xFFFF, start one cycle -> 16 busy cycles, then done pulse with out_hi=0xFFFE, out_lo=0x0001.
- Signed, opA=0xFFFF (-1), opB=0x0003 -> out_hi=0xFFFF, out_lo=0xFFFD. Same operands unsigned -> out_hi=0x0002, out_lo=0xFFFD.
- Signed, opA=0x8000, opB=0x8000 -> out_hi=0x4000, out_lo=0x0000. Signed, opA=0x8000, opB=0x0001 -> out_hi=0xFFFF, out_lo=0x8000.
- Start with 0x0003*0x0005, then pulse start with 0x0007*0x0007 at RUN cycle 5 -> second request ignored; done gives 0x0000_000F. Start again during the DONE cycle -> accepted, result 0x0000_0031 after 16 more cycles.
- rst pulsed at RUN cycle 8 of 0x1234*0x5678 -> immediately busy=0, outputs=0, no done pulse. A fresh start afterwards gives 0x0626_0060.
- With SEQ_MULT_EARLY_TERM_EN: opB=0x0001 -> done 2 cycles after accept. opB=0x0000 -> result 0 with done 2 cycles after accept. Without the macro, both take 17 cycles.
